// File: rtl/stk_mctx.sv
// stk_mctx -- multi-context LIFO stacks sharing one pool of storage lines.
//
// Each of ENGS_N engines owns a linked-list stack threaded through a shared
// pool of LINES_N lines (dat[] payload, nxt[] link). Unused lines form a free
// list. After reset the block spends LINES_N cycles (o_busy=1) chaining the
// free list, then serves one command per cycle chosen by a round-robin arbiter.
//
// Ports:
//   clk, rst      single clock, synchronous active-high reset
//   i_cmd_vld     per-engine command request
//   i_cmd_opcode  per-engine 2-bit opcode, engine e at [2e+1:2e]
//                 (0 PUSH, 1 POP, 2 PEEK, 3 reserved)
//   i_cmd_dat     per-engine push data, engine e at [e*DAT_W +: DAT_W]
//   o_cmd_ack     one-hot grant; the command is consumed this cycle
//   o_rsp_vld     one-hot response strobe, one cycle after the ack
//   o_rsp_err     response error (full on push, empty on pop/peek, bad opcode)
//   o_rsp_dat     popped/peeked entry, 0 on error and on push
//   o_busy        free-list initialisation in progress
//   o_empty       per-engine stack empty flags
//
// Build option: define STK_MCTX_PEEK_EN to enable opcode 2 (PEEK). Without it
// opcode 2 is answered as a reserved opcode.

module stk_mctx #(
  parameter int ENGS_N  = 4,
  parameter int DAT_W   = 128,
  parameter int LINES_N = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ENGS_N-1:0]       i_cmd_vld,
  input  logic [2*ENGS_N-1:0]     i_cmd_opcode,
  input  logic [ENGS_N*DAT_W-1:0] i_cmd_dat,
  output logic [ENGS_N-1:0]       o_cmd_ack,
  output logic [ENGS_N-1:0]       o_rsp_vld,
  output logic                    o_rsp_err,
  output logic [DAT_W-1:0]        o_rsp_dat,
  output logic                    o_busy,
  output logic [ENGS_N-1:0]       o_empty
);

  localparam int AW = $clog2(LINES_N);
  localparam int CW = AW + 1;
  localparam int EW = (ENGS_N > 1) ? $clog2(ENGS_N) : 1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            state;
  logic [AW-1:0]     init_idx;
  logic [DAT_W-1:0]  dat [LINES_N];
  logic [AW-1:0]     nxt [LINES_N];
  logic [AW-1:0]     head [ENGS_N];
  logic [CW-1:0]     cnt [ENGS_N];
  logic [AW-1:0]     free_head;
  logic [CW-1:0]     free_cnt;
  logic [EW-1:0]     rr_ptr;

  logic              gnt_vld_p0;
  logic [EW-1:0]     gnt_idx_p0;
  logic [1:0]        op_p0;
  logic [DAT_W-1:0]  wdat_p0;
  logic [CW-1:0]     eng_cnt_p0;
  logic [AW-1:0]     eng_head_p0;
  logic [DAT_W-1:0]  rd_dat_p0;
  logic              do_push_p0;
  logic              do_pop_p0;
  logic              rd_en_p0;
  logic              err_p0;

  logic [ENGS_N-1:0] rsp_vld_p1;
  logic              rsp_err_p1;
  logic [DAT_W-1:0]  rsp_dat_p1;
  logic [ENGS_N-1:0] empty_p1;

  // Engine index base+k, wrapped into 0..ENGS_N-1 (k < ENGS_N).
  function automatic logic [EW-1:0] rr_idx(input logic [EW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= ENGS_N) s = s - ENGS_N;
    return EW'(s);
  endfunction

  // ---- stage p0: arbitration and command decode ----
  // Scanning from the farthest offset down leaves the requester closest to
  // rr_ptr as the winner. Grants are held off during reset so a command
  // presented alongside rst is never consumed.
  always_comb begin
    gnt_vld_p0 = 1'b0;
    gnt_idx_p0 = '0;
    if (state == ST_RUN && !rst) begin
      for (int k = ENGS_N - 1; k >= 0; k--) begin
        if (i_cmd_vld[rr_idx(rr_ptr, k)]) begin
          gnt_vld_p0 = 1'b1;
          gnt_idx_p0 = rr_idx(rr_ptr, k);
        end
      end
    end
    o_cmd_ack = '0;
    if (gnt_vld_p0) o_cmd_ack[gnt_idx_p0] = 1'b1;
  end

  always_comb begin
    op_p0       = i_cmd_opcode[2*int'(gnt_idx_p0) +: 2];
    wdat_p0     = i_cmd_dat[int'(gnt_idx_p0)*DAT_W +: DAT_W];
    eng_cnt_p0  = cnt[gnt_idx_p0];
    eng_head_p0 = head[gnt_idx_p0];
    rd_dat_p0   = dat[eng_head_p0];
    do_push_p0  = 1'b0;
    do_pop_p0   = 1'b0;
    rd_en_p0    = 1'b0;
    err_p0      = 1'b0;
    if (gnt_vld_p0) begin
      case (op_p0)
        2'd0: begin
          if (free_cnt != '0) do_push_p0 = 1'b1;
          else                err_p0     = 1'b1;
        end
        2'd1: begin
          if (eng_cnt_p0 != '0) begin
            do_pop_p0 = 1'b1;
            rd_en_p0  = 1'b1;
          end else begin
            err_p0 = 1'b1;
          end
        end
`ifdef STK_MCTX_PEEK_EN
        2'd2: begin
          if (eng_cnt_p0 != '0) rd_en_p0 = 1'b1;
          else                  err_p0   = 1'b1;
        end
`endif
        default: err_p0 = 1'b1;
      endcase
    end
  end

  // ---- stage p0 -> p1: storage and link updates (not reset) ----
  always_ff @(posedge clk) begin
    rsp_dat_p1 <= rd_en_p0 ? rd_dat_p0 : '0;
    if (state == ST_INIT) begin
      // Chain line i to i+1; the last link wraps but is never followed
      // because the free count bounds every walk.
      nxt[init_idx] <= init_idx + AW'(1);
      if (init_idx == AW'(LINES_N - 1)) free_head <= '0;
    end else if (do_push_p0) begin
      dat[free_head]     <= wdat_p0;
      nxt[free_head]     <= eng_head_p0;
      head[gnt_idx_p0]   <= free_head;
      free_head          <= nxt[free_head];
    end else if (do_pop_p0) begin
      head[gnt_idx_p0]   <= nxt[eng_head_p0];
      nxt[eng_head_p0]   <= free_head;
      free_head          <= eng_head_p0;
    end
  end

  // ---- stage p0 -> p1: control state, counts and response strobes ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_INIT;
      init_idx   <= '0;
      free_cnt   <= '0;
      rr_ptr     <= '0;
      rsp_vld_p1 <= '0;
      rsp_err_p1 <= 1'b0;
      empty_p1   <= '1;
      for (int e = 0; e < ENGS_N; e++) cnt[e] <= '0;
    end else begin
      rsp_vld_p1 <= o_cmd_ack;
      rsp_err_p1 <= err_p0;
      if (state == ST_INIT) begin
        init_idx <= init_idx + AW'(1);
        if (init_idx == AW'(LINES_N - 1)) begin
          state    <= ST_RUN;
          free_cnt <= CW'(LINES_N);
        end
      end
      if (gnt_vld_p0) rr_ptr <= rr_idx(gnt_idx_p0, 1);
      if (do_push_p0) begin
        cnt[gnt_idx_p0]      <= eng_cnt_p0 + CW'(1);
        free_cnt             <= free_cnt - CW'(1);
        empty_p1[gnt_idx_p0] <= 1'b0;
      end else if (do_pop_p0) begin
        cnt[gnt_idx_p0]      <= eng_cnt_p0 - CW'(1);
        free_cnt             <= free_cnt + CW'(1);
        empty_p1[gnt_idx_p0] <= (eng_cnt_p0 == CW'(1));
      end
    end
  end

  assign o_rsp_vld = rsp_vld_p1;
  assign o_rsp_err = rsp_err_p1;
  assign o_rsp_dat = rsp_dat_p1;
  assign o_empty   = empty_p1;
  assign o_busy    = (state == ST_INIT);

endmodule

// File: tb/tb_stk_mctx.sv
// tb_stk_mctx -- bench for stk_mctx (ENGS_N=4, DAT_W=128, LINES_N=4).
// A stack-of-arrays model tracks every engine's contents and predicts grant,
// busy, empty and response outputs each cycle; directed sequences add literal
// expectations, then a randomized phase exercises the model.

module tb_stk_mctx;
  localparam int EN = 4;
  localparam int DW = 128;
  localparam int LN = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [EN-1:0]    vld;
  logic [2*EN-1:0]  opc;
  logic [EN*DW-1:0] dat;
  logic [EN-1:0]    o_cmd_ack;
  logic [EN-1:0]    o_rsp_vld;
  logic             o_rsp_err;
  logic [DW-1:0]    o_rsp_dat;
  logic             o_busy;
  logic [EN-1:0]    o_empty;

  stk_mctx #(.ENGS_N(EN), .DAT_W(DW), .LINES_N(LN)) dut (
    .clk(clk), .rst(rst),
    .i_cmd_vld(vld), .i_cmd_opcode(opc), .i_cmd_dat(dat),
    .o_cmd_ack(o_cmd_ack), .o_rsp_vld(o_rsp_vld), .o_rsp_err(o_rsp_err),
    .o_rsp_dat(o_rsp_dat), .o_busy(o_busy), .o_empty(o_empty)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endtask

  // Reference model: each engine's stack as an array with a depth count.
  logic [DW-1:0] mstk [EN][LN];
  int            msz  [EN];
  int            mptr = 0;
  int            init_left = 0;
  bit            model_ok = 1'b0;
  logic [EN-1:0] pend_vld = '0;
  logic          pend_err = 1'b0;
  logic [DW-1:0] pend_dat = '0;

  always @(negedge clk) begin
    int g;
    int tot;
    logic [EN-1:0] eack;
    logic [EN-1:0] eemp;
    logic [1:0]    op;
    logic [DW-1:0] d;
    g = -1;
    if (!rst && model_ok && init_left == 0) begin
      for (int k = 0; k < EN; k++)
        if (g < 0 && vld[(mptr + k) % EN]) g = (mptr + k) % EN;
    end
    eack = '0;
    if (g >= 0) eack[g] = 1'b1;
    chk("ack", DW'(o_cmd_ack), DW'(eack));
    if (model_ok) begin
      for (int e = 0; e < EN; e++) eemp[e] = (msz[e] == 0);
      chk("busy", DW'(o_busy), DW'(init_left > 0));
      chk("empty", DW'(o_empty), DW'(eemp));
      chk("rsp_vld", DW'(o_rsp_vld), DW'(pend_vld));
      if (pend_vld != '0) begin
        chk("rsp_err", DW'(o_rsp_err), DW'(pend_err));
        chk("rsp_dat", o_rsp_dat, pend_dat);
      end
    end
    if (rst) begin
      init_left = LN;
      mptr      = 0;
      pend_vld  = '0;
      pend_err  = 1'b0;
      pend_dat  = '0;
      for (int e = 0; e < EN; e++) msz[e] = 0;
      model_ok  = 1'b1;
    end else if (model_ok) begin
      pend_vld = eack;
      pend_err = 1'b0;
      pend_dat = '0;
      if (init_left > 0) begin
        init_left--;
      end else if (g >= 0) begin
        mptr = (g + 1) % EN;
        op   = opc[2*g +: 2];
        d    = dat[g*DW +: DW];
        tot  = 0;
        for (int e = 0; e < EN; e++) tot += msz[e];
        case (op)
          2'd0: if (tot < LN) begin mstk[g][msz[g]] = d; msz[g]++; end
                else pend_err = 1'b1;
          2'd1: if (msz[g] > 0) begin msz[g]--; pend_dat = mstk[g][msz[g]]; end
                else pend_err = 1'b1;
`ifdef STK_MCTX_PEEK_EN
          2'd2: if (msz[g] > 0) pend_dat = mstk[g][msz[g]-1];
                else pend_err = 1'b1;
`endif
          default: pend_err = 1'b1;
        endcase
      end
    end
  end

  // Issue one command from engine e alone; return the response it gets.
  task automatic cmd(input int e, input logic [1:0] op, input logic [DW-1:0] d,
                     output logic rv, output logic err, output logic [DW-1:0] rd);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    vld = '0;
    vld[e] = 1'b1;
    opc[e*2 +: 2] = op;
    dat[e*DW +: DW] = d;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk); #1;
      got = o_cmd_ack[e];
      @(posedge clk); #1;
      if (got) break;
    end
    vld = '0;
    if (!got) chk("ack_timeout", 0, 1);
    @(negedge clk); #1;
    rv  = o_rsp_vld[e];
    err = o_rsp_err;
    rd  = o_rsp_dat;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_busy;
    int n_rv;
    int n_ack;
    logic rv;
    logic err;
    logic [DW-1:0] rd;
    logic [EN-1:0] acks [5];
    logic [EN-1:0] rvs  [6];
    int ord [5];
    ord = '{0, 1, 2, 3, 0};
    vld = '0; opc = '0; dat = '0; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    // Engine 0 requests a reserved opcode throughout init: no ack until RUN.
    vld[0] = 1'b1; opc[1:0] = 2'd3;
    n_busy = 0; n_ack = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk); #1;
      if (!o_busy) break;
      n_busy++;
      if (o_cmd_ack != '0) n_ack++;
    end
    chk("busy_len", DW'(n_busy), DW'(4));
    chk("ack_in_init", DW'(n_ack), DW'(0));
    chk("empty_after_rst", DW'(o_empty), DW'(4'hF));
    @(posedge clk); #1 vld = '0;

    // LIFO order on engine 0
    cmd(0, 2'd0, DW'(128'hA), rv, err, rd);
    cmd(0, 2'd0, DW'(128'hB), rv, err, rd);
    cmd(0, 2'd1, '0, rv, err, rd);
    chk("pop1_vld", DW'(rv), DW'(1));
    chk("pop1_err", DW'(err), DW'(0));
    chk("pop1_dat", rd, DW'(128'hB));
    cmd(0, 2'd1, '0, rv, err, rd);
    chk("pop2_err", DW'(err), DW'(0));
    chk("pop2_dat", rd, DW'(128'hA));
    chk("e0_empty", DW'(o_empty[0]), DW'(1));

    // Fill the pool from engines 1 and 2, then push while full
    cmd(1, 2'd0, DW'(128'h11), rv, err, rd);
    cmd(2, 2'd0, DW'(128'h21), rv, err, rd);
    cmd(1, 2'd0, DW'(128'h12), rv, err, rd);
    cmd(2, 2'd0, DW'(128'h22), rv, err, rd);
    cmd(3, 2'd0, DW'(128'h31), rv, err, rd);
    chk("full_push_err", DW'(err), DW'(1));
    chk("full_push_dat", rd, DW'(0));
    cmd(1, 2'd1, '0, rv, err, rd);
    chk("pop_when_full_err", DW'(err), DW'(0));
    chk("pop_when_full_dat", rd, DW'(128'h12));
    cmd(3, 2'd0, DW'(128'h31), rv, err, rd);
    chk("retry_push_err", DW'(err), DW'(0));

    // All engines request continuously; pointer is 0 after engine 3's grant
    @(posedge clk); #1;
    vld = '1;
    for (int e = 0; e < EN; e++) opc[e*2 +: 2] = 2'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      acks[i] = o_cmd_ack;
      rvs[i]  = o_rsp_vld;
    end
    @(posedge clk); #1 vld = '0;
    @(negedge clk); #1 rvs[5] = o_rsp_vld;
    for (int i = 0; i < 5; i++) begin
      chk("rr_order", DW'(acks[i]), DW'(4'b0001 << ord[i]));
      chk("rr_rsp_follow", DW'(rvs[i+1]), DW'(acks[i]));
    end

    // Error cases
    cmd(2, 2'd1, '0, rv, err, rd);
    chk("e2_last_pop", rd, DW'(128'h21));
    cmd(2, 2'd1, '0, rv, err, rd);
    chk("pop_empty_err", DW'(err), DW'(1));
    chk("pop_empty_dat", rd, DW'(0));
    chk("pop_empty_flag", DW'(o_empty[2]), DW'(1));
    cmd(1, 2'd3, '0, rv, err, rd);
    chk("op3_err", DW'(err), DW'(1));
    cmd(0, 2'd0, DW'(128'h5), rv, err, rd);
    cmd(0, 2'd2, '0, rv, err, rd);
`ifdef STK_MCTX_PEEK_EN
    chk("peek_err", DW'(err), DW'(0));
    chk("peek_dat", rd, DW'(128'h5));
`else
    chk("peek_reserved_err", DW'(err), DW'(1));
`endif
    cmd(0, 2'd1, '0, rv, err, rd);
    chk("after_peek_pop", rd, DW'(128'h5));

    // Reset while engine 0 is requesting
    cmd(0, 2'd0, DW'(128'h77), rv, err, rd);
    @(posedge clk); #1;
    vld[0] = 1'b1; opc[1:0] = 2'd1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; vld = '0;
    n_busy = 0; n_rv = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk); #1;
      if (o_busy) n_busy++;
      if (o_rsp_vld != '0) n_rv++;
    end
    chk("rerun_busy_len", DW'(n_busy), DW'(4));
    chk("no_rsp_after_rst", DW'(n_rv), DW'(0));
    chk("empty_after_rerst", DW'(o_empty), DW'(4'hF));
    cmd(0, 2'd1, '0, rv, err, rd);
    chk("stack_discarded", DW'(err), DW'(1));
    cmd(0, 2'd0, DW'(128'h99), rv, err, rd);
    cmd(0, 2'd1, '0, rv, err, rd);
    chk("post_rst_lifo", rd, DW'(128'h99));

    // Randomized traffic, occasional reset
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 249) == 0);
      for (int e = 0; e < EN; e++) begin
        int r;
        vld[e] = ($urandom_range(0, 2) != 0);
        r = $urandom_range(0, 9);
        opc[e*2 +: 2] = (r < 4) ? 2'd0 : (r < 8) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
        dat[e*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; vld = '0;
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stk_mctx.md
STK_MCTX -- requirements
Module: stk_mctx

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: `clk` rising edge only; `rst` sampled on that edge.
REQ-002 Parameter ENGS_N, default 4: number of engine contexts; each engine owns one LIFO stack.
REQ-003 Parameter DAT_W, default 128: width of a stack entry.
REQ-004 Parameter LINES_N, default 64: total shared line storage, a power of two, at least 2.
REQ-005 clk  in  1  clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 i_cmd_vld  in  ENGS_N  per-engine command request.
REQ-008 i_cmd_opcode  in  ENGS_N x 2  per-engine opcode: 0 PUSH, 1 POP, 2 PEEK, 3 reserved.
REQ-009 i_cmd_dat  in  ENGS_N x DAT_W  per-engine push data.
REQ-010 o_cmd_ack  out  ENGS_N  grant, one-hot or zero; the command is consumed in this cycle.
REQ-011 o_rsp_vld  out  ENGS_N  registered response strobe, one-hot or zero.
REQ-012 o_rsp_err  out  1  response error: push when storage is full, pop/peek on an empty stack, or opcode invalid.
REQ-013 o_rsp_dat  out  DAT_W  popped or peeked entry; 0 on error and on push.
REQ-014 o_busy  out  1  free-list initialisation in progress.
REQ-015 o_empty  out  ENGS_N  per-engine stack empty, registered.

Function
REQ-016 Storage SHALL be shared flop arrays: dat[LINES_N] of DAT_W bits and nxt[LINES_N] of log2(LINES_N) bits.
REQ-017 Per-engine state SHALL be a head pointer plus a count of log2(LINES_N)+1 bits.
REQ-018 Global state SHALL be a free-list head pointer plus a free count of log2(LINES_N)+1 bits.
REQ-019 The FSM SHALL have two states, INIT and RUN. INIT sets nxt[i]=i+1 for one line per cycle, starting at i=0. After line LINES_N-1 is written it moves to RUN, with free head 0 and free count LINES_N. INIT therefore lasts exactly LINES_N cycles.
REQ-020 o_busy SHALL equal 1 in INIT. o_cmd_ack SHALL be 0 in INIT.
REQ-021 In RUN, a round-robin arbiter SHALL grant at most one engine with i_cmd_vld=1 per cycle. The priority pointer moves to grantee+1 mod ENGS_N after each grant and is unchanged when there is no grant.
REQ-022 PUSH with free count>0 SHALL do the following for line L = free head:
- dat[L] = data
- nxt[L] = engine head
- engine head = L
- free head = old nxt[L]
- engine count +1, free count -1
REQ-023 POP with engine count>0 SHALL do the following for line L = engine head:
- rsp_dat = dat[L]
- engine head = nxt[L]
- nxt[L] = free head
- free head = L
- engine count -1, free count +1
REQ-024 PEEK with engine count>0 SHALL set rsp_dat = dat[engine head] and change no state.
REQ-025 All state updates SHALL take effect at the edge that ends the ack cycle T.
REQ-026 o_rsp_vld, o_rsp_err and o_rsp_dat SHALL be registered and asserted in cycle T+1 for the acked engine. A grant every cycle SHALL yield a response every cycle.
REQ-027 An erroring command SHALL be acked, SHALL change no state, and SHALL respond with o_rsp_err=1 and o_rsp_dat=0.
REQ-028 Boundary, full storage: a PUSH when free count=0 SHALL be rejected with an error while other engines' POPs still succeed. A PUSH in the cycle after a POP freed a line SHALL succeed; the update is sequential, so no bypass is needed.
REQ-029 Boundary, full count: count fields SHALL NOT wrap. An engine count of LINES_N is legal; at that point the free count is 0.
REQ-030 o_empty[e] SHALL be 1 exactly when engine e's count is 0, and SHALL reflect the updated value from T+1.

Reset
REQ-031 When rst=1, the FSM SHALL go to INIT with the init index at 0. Reset SHALL clear all engine counts, free count, rsp_vld and rsp_err, set o_empty to all-ones, and set the arbiter pointer to 0.
REQ-032 rst asserted mid-INIT or mid-RUN SHALL discard all stacks and in-flight responses; no o_rsp_vld SHALL follow. dat[] SHALL NOT be reset.

Configuration
REQ-033 With macro STK_MCTX_PEEK_EN defined, opcode 2 SHALL behave as PEEK per REQ-024.
REQ-034 Without STK_MCTX_PEEK_EN, opcode 2 SHALL be treated as reserved: acked and answered with o_rsp_err=1. No peek read path SHALL be synthesised.

Verification (ENGS_N=4, DAT_W=128, LINES_N=4)
REQ-035 Reset release: o_busy=1 for exactly 4 cycles, o_cmd_ack=0 during that time, o_empty=4'b1111.
REQ-036 Engine 0 PUSHes 0xA then 0xB, then POPs twice: responses 0xB then 0xA, err=0, then o_empty[0]=1.
REQ-037 Engines 1 and 2 together PUSH 4 lines; engine 3 then PUSHes: err=1. Engine 1 then POPs, and engine 3 retries the PUSH: it succeeds.
REQ-038 All four engines hold i_cmd_vld=1 continuously from pointer 0: acks arrive in order 0,1,2,3,0, one per cycle, with o_rsp_vld following one cycle behind each.
REQ-039 POP on empty engine 2: err=1, dat=0, counts unchanged. Opcode 3 on any engine: err=1. Opcode 2 on a stack whose top is 0x5: with STK_MCTX_PEEK_EN, dat=0x5 and the stack is unchanged; without it, err=1.
REQ-040 rst pulsed for one cycle while engine 0 has an ack pending: no o_rsp_vld afterwards, INIT reruns for 4 cycles, all engines are empty, and the first PUSH uses line 0.
